// File: rtl/bitstream_loader.sv
// bitstream_loader
// Takes configuration words from a host over a valid/ready handshake and
// shifts them MSB first into a daisy-chained tile configuration shift chain.
// One bit moves per clock while the word register holds bits. A new word can
// be accepted on the clock that shifts the last bit of the previous word, so
// back-to-back words stream with no gap. Any bits of a final word that lie
// beyond the end of the chain are dropped.
module bitstream_loader #(
   parameter int WORD_WIDTH   = 8,
   parameter int CHAIN_LENGTH = 1152,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  config_clock,
   input  logic                  config_nreset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  config_out,
   output logic                  config_enable,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  bit_count
);

   // The occupancy counter must be able to hold the full word width.
   localparam int OCC_WIDTH = $clog2(WORD_WIDTH + 1);
   // One extra bit so that count + occupancy cannot wrap.
   localparam int CW1 = CNT_WIDTH + 1;
   localparam logic [CW1-1:0] CHAIN_LEN_W = CW1'(CHAIN_LENGTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic [OCC_WIDTH-1:0]  occ_q, occ_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  in_load;
   logic                  shift_en;
   logic                  room_ok;
   logic                  ready_int;
   logic                  xfer;
   logic                  last_bit;
   logic [CW1-1:0]        committed_bits;

   assign in_load        = (state_q == ST_LOAD);
   assign shift_en       = in_load && (occ_q != '0);
   // Bits already shifted plus bits still waiting in the register.
   assign committed_bits = {1'b0, cnt_q} + CW1'(occ_q);
   assign room_ok        = (committed_bits < CHAIN_LEN_W);
   // Accept a word once at most one bit remains, so the new word lands right
   // behind the last bit of the current one, and only while the chain can
   // still take more bits.
   assign ready_int      = in_load && (occ_q <= OCC_WIDTH'(1)) && room_ok;
   assign xfer           = word_valid && ready_int;
   // The bit shifted this cycle is the final one of the chain.
   assign last_bit       = shift_en && (({1'b0, cnt_q} + CW1'(1)) == CHAIN_LEN_W);

   // Next-state, word register, occupancy and bit-count update.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      occ_d   = occ_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
               word_d  = '0;
               occ_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               // Abort wins over any shift, transfer or completion this
               // cycle; the count keeps the value it had when abort came in.
               state_d = ST_IDLE;
               word_d  = '0;
               occ_d   = '0;
            end else begin
               if (shift_en) begin
                  word_d = word_q << 1;
                  occ_d  = occ_q - OCC_WIDTH'(1);
                  cnt_d  = cnt_q + CNT_WIDTH'(1);
               end
               // A word accepted together with the last bit of the previous
               // word replaces the register after that bit has been shifted.
               if (xfer) begin
                  word_d = word_data;
                  occ_d  = OCC_WIDTH'(WORD_WIDTH);
               end
               // Any bits that remain in the register are never shifted out.
               if (last_bit) begin
                  state_d = ST_DONE;
                  word_d  = '0;
                  occ_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status flags follow the next state, so they change on the same edge as the state.
   always_comb begin
      busy_d = (state_d == ST_LOAD);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers; reset clears them immediately.
   always_ff @(posedge config_clock or negedge config_nreset) begin
      if (!config_nreset) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         occ_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // config_enable and config_out are driven from registers with no extra
   // flop, so the chain captures the current MSB on the same clock edge.
   assign config_enable = shift_en;
   assign config_out    = word_q[WORD_WIDTH-1];
   assign word_ready    = ready_int;
   assign busy          = busy_q;
   assign done          = done_q;
   assign bit_count     = cnt_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader
// Three loaders sharing one clock and reset, with chain lengths 20, 16 and 72.
// The 72-bit loader drives two daisy-chained 36-bit tile registers.
// A monitor records every bit presented on config_out while config_enable is
// high. Each scenario compares the recorded bits with the stream built from
// the words it sent.
module tb_bitstream_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_s [3];
   logic       abort_s [3];
   logic       valid_s [3];
   logic [7:0] data_s  [3];
   logic       ready_s [3];
   logic       out_s   [3];
   logic       en_s    [3];
   logic       busy_s  [3];
   logic       done_s  [3];
   logic [15:0] cnt_s  [3];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20), .CNT_WIDTH(16)) u_l20 (
      .config_clock(clk), .config_nreset(rst_n), .start(start_s[0]), .abort(abort_s[0]),
      .word_data(data_s[0]), .word_valid(valid_s[0]), .word_ready(ready_s[0]),
      .config_out(out_s[0]), .config_enable(en_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .bit_count(cnt_s[0]));

   bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(16), .CNT_WIDTH(16)) u_l16 (
      .config_clock(clk), .config_nreset(rst_n), .start(start_s[1]), .abort(abort_s[1]),
      .word_data(data_s[1]), .word_valid(valid_s[1]), .word_ready(ready_s[1]),
      .config_out(out_s[1]), .config_enable(en_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .bit_count(cnt_s[1]));

   bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(72), .CNT_WIDTH(16)) u_l72 (
      .config_clock(clk), .config_nreset(rst_n), .start(start_s[2]), .abort(abort_s[2]),
      .word_data(data_s[2]), .word_valid(valid_s[2]), .word_ready(ready_s[2]),
      .config_out(out_s[2]), .config_enable(en_s[2]), .busy(busy_s[2]), .done(done_s[2]),
      .bit_count(cnt_s[2]));

   // Two 36-bit tile configuration registers daisy-chained behind the 72-bit loader.
   logic [35:0] tile0, tile1;
   always @(posedge clk) begin
      if (en_s[2] === 1'b1) begin
         tile0 <= {tile0[34:0], out_s[2]};
         tile1 <= {tile1[34:0], tile0[35]};
      end
   end

   // Record each bit the chain would capture, along with the cycle number.
   int cyc = 0;
   bit mon_bits [3][1024];
   int mon_cyc  [3][1024];
   int mon_n    [3] = '{0, 0, 0};
   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 3; k++) begin
         if (en_s[k] === 1'b1 && mon_n[k] < 1024) begin
            mon_bits[k][mon_n[k]] <= out_s[k];
            mon_cyc[k][mon_n[k]]  <= cyc;
            mon_n[k]              <= mon_n[k] + 1;
         end
      end
   end

   // Words the host has transferred during the current load.
   logic [7:0] sent_q[$];

   // Reference stream: bit i is bit (7 - i%8) of word i/8, cut off at cl bits.
   function automatic logic [127:0] stream_of(input int cl);
      logic [127:0] s;
      s = '0;
      for (int i = 0; i < cl; i++) begin
         logic [7:0] w;
         w = 8'h00;
         if (i / 8 < sent_q.size()) w = sent_q[i / 8];
         s[i] = w[7 - (i % 8)];
      end
      return s;
   endfunction

   function automatic logic [127:0] obs_of(input int k, input int base, input int cl);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < cl; i++) begin
         if (base + i < 1024) o[i] = mon_bits[k][base + i];
      end
      return o;
   endfunction

   task automatic do_start(input int k);
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
   endtask

   // Present a word with valid held and wait until it is accepted. Returns on
   // the falling edge after the transfer edge.
   task automatic feed(input int k, input logic [7:0] w);
      int t;
      data_s[k]  = w;
      valid_s[k] = 1'b1;
      t = 0;
      while (ready_s[k] !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         chk_cnt++;
         $display("FAIL feed_timeout inst=%0d ready=%b want 1", k, ready_s[k]);
      end else begin
         sent_q.push_back(w);
         @(negedge clk);
      end
   endtask

   task automatic wait_done(input int k);
      int t;
      t = 0;
      while (done_s[k] !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
   endtask

   // Send n random words, with a random idle gap of up to max_gap cycles before each one.
   task automatic load_random(input int k, input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         valid_s[k] = 1'b0;
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         feed(k, 8'($urandom));
      end
      valid_s[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_s[k] = 1'b0; abort_s[k] = 1'b0; valid_s[k] = 1'b0; data_s[k] = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk_cnt++;
         if ({ready_s[k], out_s[k], en_s[k], busy_s[k], done_s[k], cnt_s[k]} !== 21'd0)
            $display("FAIL reset_outputs inst=%0d got %b want all zero", k,
                     {ready_s[k], out_s[k], en_s[k], busy_s[k], done_s[k], cnt_s[k]});
         else pass_cnt++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("test_reset: outputs of 3 loaders sampled under reset");
   endtask

   task automatic test_back_to_back();
      int base, t;
      bit ready_seen;
      logic [19:0] ser;
      sent_q.delete();
      base = mon_n[0];
      do_start(0);
      chk_cnt++;
      if (busy_s[0] !== 1'b1 || cnt_s[0] !== 16'd0)
         $display("FAIL b2b_start got busy=%b cnt=%0d want busy=1 cnt=0", busy_s[0], cnt_s[0]);
      else pass_cnt++;
      feed(0, 8'hA5);
      feed(0, 8'h3C);
      feed(0, 8'hF0);
      // Keep valid high with a fourth word; the loader must not take it.
      data_s[0] = 8'h77;
      ready_seen = 1'b0;
      t = 0;
      while (done_s[0] !== 1'b1 && t < 100) begin
         if (ready_s[0] === 1'b1) ready_seen = 1'b1;
         @(negedge clk);
         t++;
      end
      repeat (3) begin
         if (ready_s[0] === 1'b1) ready_seen = 1'b1;
         @(negedge clk);
      end
      valid_s[0] = 1'b0;
      for (int i = 0; i < 20; i++) ser[19 - i] = mon_bits[0][base + i];
      chk_cnt++;
      if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0)
         $display("FAIL b2b_done got done=%b busy=%b want 1/0", done_s[0], busy_s[0]);
      else pass_cnt++;
      chk_cnt++;
      if (cnt_s[0] !== 16'd20) $display("FAIL b2b_bit_count got %0d want 20", cnt_s[0]);
      else pass_cnt++;
      chk_cnt++;
      if (mon_n[0] - base !== 20) $display("FAIL b2b_bits_shifted got %0d want 20", mon_n[0] - base);
      else pass_cnt++;
      chk_cnt++;
      if (ser !== 20'b1010_0101_0011_1100_1111)
         $display("FAIL b2b_serial got %b want 10100101001111001111", ser);
      else pass_cnt++;
      chk_cnt++;
      if (mon_cyc[0][base + 19] - mon_cyc[0][base] !== 19)
         $display("FAIL b2b_consecutive got span %0d want 19", mon_cyc[0][base + 19] - mon_cyc[0][base]);
      else pass_cnt++;
      chk_cnt++;
      if (ready_seen !== 1'b0) $display("FAIL b2b_ready_after_last got 1 want 0");
      else pass_cnt++;
      $display("test_back_to_back: words A5 3C F0 -> %0d bits, cnt=%0d", mon_n[0] - base, cnt_s[0]);
   endtask

   task automatic test_stall();
      int base;
      sent_q.delete();
      base = mon_n[0];
      do_start(0);
      feed(0, 8'($urandom));
      valid_s[0] = 1'b0;
      repeat (10) @(negedge clk);
      chk_cnt++;
      if (en_s[0] !== 1'b0 || cnt_s[0] !== 16'd8)
         $display("FAIL stall_hold got en=%b cnt=%0d want en=0 cnt=8", en_s[0], cnt_s[0]);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      feed(0, 8'($urandom));
      feed(0, 8'($urandom));
      valid_s[0] = 1'b0;
      wait_done(0);
      @(negedge clk);
      chk_cnt++;
      if (mon_cyc[0][base + 8] - mon_cyc[0][base + 7] !== 6)
         $display("FAIL stall_gap got %0d idle cycles want 5", mon_cyc[0][base + 8] - mon_cyc[0][base + 7] - 1);
      else pass_cnt++;
      chk_cnt++;
      if (mon_n[0] - base !== 20 || cnt_s[0] !== 16'd20 || done_s[0] !== 1'b1)
         $display("FAIL stall_total got bits=%0d cnt=%0d done=%b want 20/20/1", mon_n[0] - base, cnt_s[0], done_s[0]);
      else pass_cnt++;
      chk_cnt++;
      if (obs_of(0, base, 20) !== stream_of(20))
         $display("FAIL stall_stream got %h want %h", obs_of(0, base, 20), stream_of(20));
      else pass_cnt++;
      $display("test_stall: gap of 5 after bit 8, %0d bits total", mon_n[0] - base);
   endtask

   task automatic test_abort();
      int base, t;
      sent_q.delete();
      do_start(0);
      feed(0, 8'($urandom));
      feed(0, 8'($urandom));
      valid_s[0] = 1'b0;
      t = 0;
      while (cnt_s[0] !== 16'd11 && t < 50) begin
         @(negedge clk);
         t++;
      end
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      chk_cnt++;
      if (busy_s[0] !== 1'b0 || en_s[0] !== 1'b0 || done_s[0] !== 1'b0 || ready_s[0] !== 1'b0)
         $display("FAIL abort_idle got busy=%b en=%b done=%b ready=%b want 0/0/0/0",
                  busy_s[0], en_s[0], done_s[0], ready_s[0]);
      else pass_cnt++;
      chk_cnt++;
      if (cnt_s[0] !== 16'd11) $display("FAIL abort_count got %0d want 11", cnt_s[0]);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      sent_q.delete();
      base = mon_n[0];
      do_start(0);
      chk_cnt++;
      if (cnt_s[0] !== 16'd0 || busy_s[0] !== 1'b1)
         $display("FAIL abort_restart got cnt=%0d busy=%b want 0/1", cnt_s[0], busy_s[0]);
      else pass_cnt++;
      load_random(0, 3, 0);
      wait_done(0);
      @(negedge clk);
      chk_cnt++;
      if (obs_of(0, base, 20) !== stream_of(20) || mon_n[0] - base !== 20)
         $display("FAIL abort_reload_stream got %h (%0d bits) want %h (20 bits)",
                  obs_of(0, base, 20), mon_n[0] - base, stream_of(20));
      else pass_cnt++;
      // Abort while DONE has no effect.
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (done_s[0] !== 1'b1 || cnt_s[0] !== 16'd20)
         $display("FAIL abort_in_done got done=%b cnt=%0d want 1/20", done_s[0], cnt_s[0]);
      else pass_cnt++;
      $display("test_abort: aborted at 11, reload produced %0d bits", mon_n[0] - base);
   endtask

   task automatic test_exact_multiple();
      int base, t;
      bit ready_seen;
      sent_q.delete();
      base = mon_n[1];
      do_start(1);
      feed(1, 8'($urandom));
      feed(1, 8'($urandom));
      data_s[1]  = 8'($urandom);
      valid_s[1] = 1'b1;
      ready_seen = 1'b0;
      t = 0;
      while (!(cnt_s[1] === 16'd15 && en_s[1] === 1'b1) && t < 50) begin
         if (ready_s[1] === 1'b1) ready_seen = 1'b1;
         @(negedge clk);
         t++;
      end
      if (ready_s[1] === 1'b1) ready_seen = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (done_s[1] !== 1'b1 || busy_s[1] !== 1'b0 || cnt_s[1] !== 16'd16)
         $display("FAIL exact_done got done=%b busy=%b cnt=%0d want 1/0/16", done_s[1], busy_s[1], cnt_s[1]);
      else pass_cnt++;
      repeat (4) begin
         if (ready_s[1] === 1'b1) ready_seen = 1'b1;
         @(negedge clk);
      end
      valid_s[1] = 1'b0;
      chk_cnt++;
      if (ready_seen !== 1'b0 || mon_n[1] - base !== 16)
         $display("FAIL exact_no_third got ready_seen=%b bits=%0d want 0/16", ready_seen, mon_n[1] - base);
      else pass_cnt++;
      chk_cnt++;
      if (obs_of(1, base, 16) !== stream_of(16))
         $display("FAIL exact_stream got %h want %h", obs_of(1, base, 16), stream_of(16));
      else pass_cnt++;
      $display("test_exact_multiple: 2 words -> %0d bits, done=%b", mon_n[1] - base, done_s[1]);
   endtask

   task automatic test_async_reset();
      int base, t;
      sent_q.delete();
      do_start(0);
      feed(0, 8'($urandom) | 8'h01);
      valid_s[0] = 1'b0;
      t = 0;
      while (cnt_s[0] !== 16'd5 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk_cnt++;
      if (en_s[0] !== 1'b1) $display("FAIL areset_pre got en=%b want 1", en_s[0]);
      else pass_cnt++;
      // Drop reset between clock edges; the outputs must clear right away.
      #1 rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({ready_s[0], out_s[0], en_s[0], busy_s[0], done_s[0], cnt_s[0]} !== 21'd0)
         $display("FAIL areset_outputs got %b want all zero",
                  {ready_s[0], out_s[0], en_s[0], busy_s[0], done_s[0], cnt_s[0]});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sent_q.delete();
      base = mon_n[0];
      do_start(0);
      load_random(0, 3, 1);
      wait_done(0);
      @(negedge clk);
      chk_cnt++;
      if (obs_of(0, base, 20) !== stream_of(20) || cnt_s[0] !== 16'd20 || done_s[0] !== 1'b1)
         $display("FAIL areset_reload got %h cnt=%0d done=%b want %h cnt=20 done=1",
                  obs_of(0, base, 20), cnt_s[0], done_s[0], stream_of(20));
      else pass_cnt++;
      $display("test_async_reset: reset at bit 5, reload cnt=%0d", cnt_s[0]);
   endtask

   task automatic test_chain();
      int base;
      logic [127:0] s;
      logic [71:0] exp72;
      sent_q.delete();
      base = mon_n[2];
      do_start(2);
      load_random(2, 9, 3);
      wait_done(2);
      @(negedge clk);
      s = stream_of(72);
      for (int i = 0; i < 72; i++) exp72[71 - i] = s[i];
      chk_cnt++;
      if ({tile1, tile0} !== exp72)
         $display("FAIL chain_contents got %h want %h", {tile1, tile0}, exp72);
      else pass_cnt++;
      chk_cnt++;
      if (mon_n[2] - base !== 72 || cnt_s[2] !== 16'd72 || done_s[2] !== 1'b1)
         $display("FAIL chain_count got bits=%0d cnt=%0d done=%b want 72/72/1", mon_n[2] - base, cnt_s[2], done_s[2]);
      else pass_cnt++;
      $display("test_chain: 72 bits, tiles=%h", {tile1, tile0});
   endtask

   task automatic test_random();
      int base;
      for (int it = 0; it < 4; it++) begin
         sent_q.delete();
         base = mon_n[0];
         do_start(0);
         load_random(0, 3, 4);
         wait_done(0);
         @(negedge clk);
         chk_cnt++;
         if (obs_of(0, base, 20) !== stream_of(20))
            $display("FAIL random_stream it=%0d got %h want %h", it, obs_of(0, base, 20), stream_of(20));
         else pass_cnt++;
         chk_cnt++;
         if (mon_n[0] - base !== 20 || cnt_s[0] !== 16'd20 || done_s[0] !== 1'b1)
            $display("FAIL random_total it=%0d got bits=%0d cnt=%0d done=%b want 20/20/1",
                     it, mon_n[0] - base, cnt_s[0], done_s[0]);
         else pass_cnt++;
         $display("test_random: it=%0d words %h %h %h", it, sent_q[0], sent_q[1], sent_q[2]);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_abort();
      test_exact_multiple();
      test_async_reset();
      test_chain();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
